// File: rtl/card_dealer_ctrl_if.sv
// ============================================================================
// Module   : card_dealer_ctrl_if
// Purpose  : Counter request/index pair plus the card valid/ready handshake.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface card_dealer_ctrl_if;
  logic       req_card_o;
  logic [7:0] card_idx_i;
  logic       card_valid_o;
  logic       card_ready_i;
  logic [5:0] card_idx_o;
  logic [3:0] card_rank_o;
  logic [1:0] card_suit_o;
  logic [3:0] card_points_o;

  modport master (
    output req_card_o,
    input  card_idx_i,
    output card_valid_o,
    input  card_ready_i,
    output card_idx_o,
    output card_rank_o,
    output card_suit_o,
    output card_points_o
  );

  modport slave (
    input  req_card_o,
    output card_idx_i,
    input  card_valid_o,
    output card_ready_i,
    input  card_idx_o,
    input  card_rank_o,
    input  card_suit_o,
    input  card_points_o
  );
endinterface

`default_nettype wire

// File: rtl/card_dealer_ctrl.sv
// ============================================================================
// Module   : card_dealer_ctrl
// Purpose  : Freezes a free-running card counter, rejects empty/dealt indices
//            by re-spinning, and presents decoded cards over valid/ready.
// Revision : 1.0
// ============================================================================
`default_nettype none

module card_dealer_ctrl #(
  parameter int RETRY_SPIN = 3,
  parameter int DECK_SIZE  = 52
) (
  input  wire logic            clk_cd_i,
  input  wire logic            rst_cd_i,
  input  wire logic            shuffle_i,
  input  wire logic            deal_req_i,
  card_dealer_ctrl_if.master   dif,
  output logic                 busy_o,
  output logic                 deck_empty_o,
  output logic [5:0]           dealt_count_o
);

  typedef enum logic [2:0] {
    ST_SPIN    = 3'd0,
    ST_SETTLE  = 3'd1,
    ST_CHECK   = 3'd2,
    ST_RESPIN  = 3'd3,
    ST_PRESENT = 3'd4
  } state_t;

  state_t      state_q;
  logic        req_q;
  logic        valid_q;
  logic [5:0]  idx_q;
  logic [3:0]  rank_q;
  logic [1:0]  suit_q;
  logic [3:0]  points_q;
  logic [63:0] bitmap_q;
  logic [5:0]  count_q;
  logic [5:0]  retry_q;

  logic [5:0]  idx_d;
  logic [5:0]  off_d;
  logic [3:0]  rank_d;
  logic [1:0]  suit_d;
  logic [3:0]  points_d;
  logic        reject_d;

  assign idx_d = dif.card_idx_i[5:0];
  assign off_d = idx_d - 6'd1;

  // Range is tested on the full 8-bit index before the bitmap lookup uses bits 5:0.
  assign reject_d = (dif.card_idx_i == 8'd0) ||
                    (dif.card_idx_i > 8'(DECK_SIZE)) ||
                    bitmap_q[idx_d];

  always_comb begin
    suit_d = 2'd0;
    rank_d = 4'd0;
    if (off_d < 6'd13) begin
      suit_d = 2'd0;
      rank_d = 4'(off_d + 6'd1);
    end else if (off_d < 6'd26) begin
      suit_d = 2'd1;
      rank_d = 4'(off_d - 6'd12);
    end else if (off_d < 6'd39) begin
      suit_d = 2'd2;
      rank_d = 4'(off_d - 6'd25);
    end else begin
      suit_d = 2'd3;
      rank_d = 4'(off_d - 6'd38);
    end
    if (rank_d == 4'd1) begin
      points_d = 4'd11;
    end else if (rank_d > 4'd10) begin
      points_d = 4'd10;
    end else begin
      points_d = rank_d;
    end
  end

  always_ff @(posedge clk_cd_i or negedge rst_cd_i) begin
    if (!rst_cd_i) begin
      state_q  <= ST_SPIN;
      req_q    <= 1'b1;
      valid_q  <= 1'b0;
      idx_q    <= 6'd0;
      rank_q   <= 4'd0;
      suit_q   <= 2'd0;
      points_q <= 4'd0;
      bitmap_q <= 64'd0;
      count_q  <= 6'd0;
      retry_q  <= 6'd0;
    end else if (shuffle_i) begin
      state_q  <= ST_SPIN;
      req_q    <= 1'b1;
      valid_q  <= 1'b0;
      bitmap_q <= 64'd0;
      count_q  <= 6'd0;
      retry_q  <= 6'd0;
    end else begin
      case (state_q)
        ST_SPIN: begin
          req_q <= 1'b1;
          if (deal_req_i && !deck_empty_o) begin
            req_q   <= 1'b0;
            state_q <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          state_q <= ST_CHECK;
        end
        ST_CHECK: begin
          if (reject_d) begin
            req_q   <= 1'b1;
            retry_q <= 6'd0;
            state_q <= ST_RESPIN;
          end else begin
            bitmap_q[idx_d] <= 1'b1;
            count_q  <= count_q + 6'd1;
            idx_q    <= idx_d;
            rank_q   <= rank_d;
            suit_q   <= suit_d;
            points_q <= points_d;
            valid_q  <= 1'b1;
            state_q  <= ST_PRESENT;
          end
        end
        ST_RESPIN: begin
          // req_q went high on the CHECK edge, so dropping it on the last
          // RESPIN edge yields exactly RETRY_SPIN counter increments.
          if (retry_q == 6'(RETRY_SPIN - 1)) begin
            req_q   <= 1'b0;
            state_q <= ST_SETTLE;
          end else begin
            retry_q <= retry_q + 6'd1;
          end
        end
        ST_PRESENT: begin
          if (dif.card_ready_i) begin
            valid_q <= 1'b0;
            req_q   <= 1'b1;
            state_q <= ST_SPIN;
          end
        end
        default: begin
          state_q <= ST_SPIN;
          req_q   <= 1'b1;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign dif.req_card_o    = req_q;
  assign dif.card_valid_o  = valid_q;
  assign dif.card_idx_o    = idx_q;
  assign dif.card_rank_o   = rank_q;
  assign dif.card_suit_o   = suit_q;
  assign dif.card_points_o = points_q;

  assign busy_o        = (state_q != ST_SPIN);
  assign deck_empty_o  = (count_q == 6'(DECK_SIZE));
  assign dealt_count_o = count_q;

endmodule

`default_nettype wire

// File: tb/tb_card_dealer_ctrl.sv
// ============================================================================
// Module   : tb_card_dealer_ctrl
// Purpose  : Self-checking bench with a spinning counter and a deck model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_card_dealer_ctrl;
  localparam int R = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       shuffle;
  logic       deal_req;
  logic       ready;
  logic       busy;
  logic       empty;
  logic [5:0] count;

  logic       load;
  logic [7:0] load_val;
  logic [7:0] cnt;

  int checks = 0;
  int errors = 0;
  bit dealt [0:52];
  int n_dealt;

  card_dealer_ctrl_if dif ();

  card_dealer_ctrl #(.RETRY_SPIN(R), .DECK_SIZE(52)) dut (
    .clk_cd_i     (clk),
    .rst_cd_i     (rst_n),
    .shuffle_i    (shuffle),
    .deal_req_i   (deal_req),
    .dif          (dif),
    .busy_o       (busy),
    .deck_empty_o (empty),
    .dealt_count_o(count)
  );

  always #5 clk = ~clk;

  // Counter stand-in; load lets a scenario pin the value the dealer will freeze on.
  always @(posedge clk) begin
    if (!rst_n)               cnt <= 8'd0;
    else if (load)            cnt <= load_val;
    else if (dif.req_card_o)  cnt <= (cnt == 8'd52) ? 8'd0 : cnt + 8'd1;
  end

  assign dif.card_idx_i   = cnt;
  assign dif.card_ready_i = ready;

  task automatic clear_model();
    for (int i = 0; i <= 52; i++) dealt[i] = 1'b0;
    n_dealt = 0;
  endtask

  // preset < 0: let the counter spin freely; otherwise freeze it on preset.
  task automatic deal(input int preset, input int rdelay, input bit accept);
    int v, k, exp_lat, lat, rank, suit, pts;
    logic [15:0] snap;
    bit unstable;
    @(negedge clk);
    if (preset >= 0) begin
      load = 1'b1;
      load_val = 8'(preset);
      v = preset;
    end else begin
      v = (cnt == 8'd52) ? 0 : int'(cnt) + 1;
    end
    k = 0;
    while ((v == 0 || dealt[v]) && k <= 60) begin
      v = (v + R) % 53;
      k++;
    end
    exp_lat = 3 + k * (R + 2);
    rank = ((v - 1) % 13) + 1;
    suit = (v - 1) / 13;
    pts  = (rank == 1) ? 11 : (rank > 10) ? 10 : rank;
    deal_req = 1'b1;
    @(negedge clk);
    deal_req = 1'b0;
    load = 1'b0;
    lat = 1;
    checks++;
    if (dif.req_card_o !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL freeze: req=%b busy=%b, required req=0 busy=1", dif.req_card_o, busy);
    end
    while (dif.card_valid_o !== 1'b1 && lat < 1000) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (lat != exp_lat) begin
      errors++;
      $display("FAIL latency: got %0d cycles, required %0d (idx %0d)", lat, exp_lat, v);
    end
    checks++;
    if (dif.card_idx_o !== 6'(v) || dif.card_rank_o !== 4'(rank) ||
        dif.card_suit_o !== 2'(suit) || dif.card_points_o !== 4'(pts)) begin
      errors++;
      $display("FAIL fields: idx=%0d rank=%0d suit=%0d pts=%0d, required %0d %0d %0d %0d",
               dif.card_idx_o, dif.card_rank_o, dif.card_suit_o, dif.card_points_o,
               v, rank, suit, pts);
    end
    if (v >= 1 && v <= 52) dealt[v] = 1'b1;
    n_dealt++;
    checks++;
    if (count !== 6'(n_dealt) || empty !== (n_dealt == 52)) begin
      errors++;
      $display("FAIL count: count=%0d empty=%b, required %0d %b", count, empty, n_dealt, n_dealt == 52);
    end
    snap = {dif.card_idx_o, dif.card_rank_o, dif.card_suit_o, dif.card_points_o};
    unstable = 1'b0;
    for (int i = 0; i < rdelay; i++) begin
      @(negedge clk);
      if (dif.card_valid_o !== 1'b1 ||
          {dif.card_idx_o, dif.card_rank_o, dif.card_suit_o, dif.card_points_o} !== snap)
        unstable = 1'b1;
    end
    if (rdelay > 0) begin
      checks++;
      if (unstable) begin
        errors++;
        $display("FAIL hold: card changed while stalled for %0d cycles, required stable", rdelay);
      end
    end
    if (accept) begin
      ready = 1'b1;
      @(negedge clk);
      ready = 1'b0;
      checks++;
      if (dif.card_valid_o !== 1'b0 || dif.req_card_o !== 1'b1 || busy !== 1'b0 ||
          {dif.card_idx_o, dif.card_rank_o, dif.card_suit_o, dif.card_points_o} !== snap) begin
        errors++;
        $display("FAIL accept: valid=%b req=%b busy=%b fields=%h, required 0 1 0 %h",
                 dif.card_valid_o, dif.req_card_o, busy,
                 {dif.card_idx_o, dif.card_rank_o, dif.card_suit_o, dif.card_points_o}, snap);
      end
    end
  endtask

  task automatic check_idle(input string name, input logic exp_empty, input int exp_cnt);
    checks++;
    if (dif.req_card_o !== 1'b1 || dif.card_valid_o !== 1'b0 || busy !== 1'b0 ||
        empty !== exp_empty || count !== 6'(exp_cnt)) begin
      errors++;
      $display("FAIL %s: req=%b valid=%b busy=%b empty=%b count=%0d, required 1 0 0 %b %0d",
               name, dif.req_card_o, dif.card_valid_o, busy, empty, count, exp_empty, exp_cnt);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; shuffle = 1'b0; deal_req = 1'b0; ready = 1'b0;
    load = 1'b0; load_val = 8'd0;
    clear_model();
    repeat (3) @(negedge clk);
    check_idle("reset", 1'b0, 0);
    checks++;
    if ({dif.card_idx_o, dif.card_rank_o, dif.card_suit_o, dif.card_points_o} !== 16'd0) begin
      errors++;
      $display("FAIL reset_fields: got %h, required 0",
               {dif.card_idx_o, dif.card_rank_o, dif.card_suit_o, dif.card_points_o});
    end
    rst_n = 1'b1;
    repeat (60) @(negedge clk);
    checks++;
    if (cnt !== 8'(60 % 53)) begin
      errors++;
      $display("FAIL spin: counter=%0d after 60 cycles, required %0d", cnt, 60 % 53);
    end
  endtask

  task automatic test_single_deal();
    deal(14, 0, 1'b1);
  endtask

  task automatic test_reject_zero();
    deal(0, 0, 1'b1);
  endtask

  task automatic test_reject_dealt();
    deal(26, 0, 1'b1);
    deal(26, 10, 1'b1);
  endtask

  task automatic test_deck_empty();
    while (n_dealt < 52) begin
      repeat ($urandom_range(0, 40)) @(negedge clk);
      deal(-1, $urandom_range(0, 3), 1'b1);
    end
    @(negedge clk);
    check_idle("full_deck", 1'b1, 52);
    deal_req = 1'b1;
    @(negedge clk);
    deal_req = 1'b0;
    repeat (3) @(negedge clk);
    check_idle("deal_on_empty", 1'b1, 52);
    shuffle = 1'b1;
    @(negedge clk);
    shuffle = 1'b0;
    clear_model();
    check_idle("shuffle", 1'b0, 0);
    deal(13, 0, 1'b1);
  endtask

  task automatic test_shuffle_present();
    deal(5, 0, 1'b0);
    shuffle = 1'b1;
    deal_req = 1'b1;
    @(negedge clk);
    shuffle = 1'b0;
    deal_req = 1'b0;
    clear_model();
    check_idle("shuffle_present", 1'b0, 0);
    repeat (2) @(negedge clk);
    check_idle("shuffle_drops_deal", 1'b0, 0);
    deal(5, 0, 1'b1);
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    load = 1'b1; load_val = 8'd0; deal_req = 1'b1;
    @(negedge clk);
    load = 1'b0; deal_req = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (dif.req_card_o !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL respin: req=%b busy=%b, required 1 1", dif.req_card_o, busy);
    end
    #2 rst_n = 1'b0;
    #1;
    check_idle("async_reset", 1'b0, 0);
    clear_model();
    @(negedge clk);
    rst_n = 1'b1;
    deal(0, 0, 1'b1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_single_deal();
    test_reject_zero();
    test_reject_dealt();
    test_deck_empty();
    test_shuffle_present();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/card_dealer_ctrl.md
Name: card_dealer_ctrl

Overview:
- Initiator side of the card-index counter handshake.
- The counter advances every clock while its request input is high, wraps 52→0, and holds when the request is low.
- This block holds the request high to spin the counter while idle. On a deal request from the game FSM it freezes the counter, samples the index and rejects index 0 or already-dealt cards by re-spinning.
- It decodes each accepted index to rank, suit and blackjack points, then presents the card to the game FSM over a valid/ready handshake.

Parameters:
- RETRY_SPIN, 3, cycles req_card_o is held high on a rejected sample (legal 1..52; 53 is prime, so every step size visits all indices).
- DECK_SIZE, 52, number of valid card indices 1..DECK_SIZE (fixed at 52; not to be overridden).

Ports:
- clk_cd_i  input  1  clock.
- rst_cd_i  input  1  reset, asynchronous, active-low.
- shuffle_i  input  1  one-cycle pulse: clear the dealt bitmap and count.
- deal_req_i  input  1  one-cycle pulse: request one card.
- card_idx_i  input  8  index from the counter (its next_card_o).
- req_card_o  output  1  registered; drives the counter's request input (1 = spin).
- card_valid_o  output  1  card fields are valid.
- card_ready_i  input  1  game FSM accepts the card.
- card_idx_o  output  6  accepted index 1..52.
- card_rank_o  output  4  1..13 (1 = ace, 11..13 = J/Q/K).
- card_suit_o  output  2  0..3.
- card_points_o  output  4  ace = 11, 2..10 = rank, J/Q/K = 10.
- busy_o  output  1  high in any state other than SPIN.
- deck_empty_o  output  1  dealt_count == 52.
- dealt_count_o  output  6  cards dealt since reset or shuffle.

Behaviour:
- Reset values:
  - State = SPIN.
  - req_card_o = 1.
  - card_valid_o = 0.
  - Card fields = 0.
  - Bitmap = all 0.
  - dealt_count_o = 0.
  - busy_o = 0.
  - deck_empty_o = 0.
  - Retry counter = 0.
- Reset mid-operation aborts any pending card with no partial update.
- SPIN:
  - req_card_o = 1.
  - deal_req_i with deck_empty_o = 0 → SETTLE and req_card_o <= 0.
  - deal_req_i while deck_empty_o = 1 is ignored; state stays SPIN.
- SETTLE (1 cycle): the counter has seen its final increment and is now frozen → CHECK.
- CHECK:
  - Register card_idx_i.
  - Rejected if idx == 0, idx > 52, or bitmap[idx] == 1 → RESPIN.
  - Otherwise:
    - Set bitmap[idx].
    - Increment dealt_count.
    - Register the decode.
    - card_valid_o <= 1 → PRESENT.
- RESPIN:
  - req_card_o = 1 for exactly RETRY_SPIN cycles.
  - Then req_card_o <= 0 → SETTLE.
  - Because the deck is not empty, termination within 53 retries is guaranteed.
- PRESENT:
  - card_valid_o and all card fields are held stable until card_ready_i = 1.
  - On the accept cycle: card_valid_o <= 0, req_card_o <= 1 → SPIN.
  - Card fields retain their last values after acceptance.
- Decode: rank = ((idx−1) mod 13) + 1; suit = (idx−1) div 13; points as in the port list. Computed from the 6-bit idx with no truncation beyond bit 5.
- Latency:
  - deal_req_i at cycle T, no retry → card_valid_o high from T+3.
  - Each rejection adds RETRY_SPIN + 2 cycles.
- Simultaneous events:
  - deal_req_i outside SPIN is ignored (no queuing).
  - shuffle_i takes priority over all state transitions:
    - Clears the bitmap and count.
    - Drops card_valid_o.
    - Forces SPIN with req_card_o = 1.
  - A card in PRESENT is discarded when a shuffle arrives.
  - shuffle_i together with deal_req_i: the shuffle wins and the deal is dropped.
- deck_empty_o:
  - Asserts the cycle after the 52nd card is accepted into the bitmap.
  - Clears only on shuffle or reset.

Test Plan:
1. Reset → req_card_o = 1, card_valid_o = 0, dealt_count_o = 0, busy_o = 0; release reset, counter model spins 0..52.
2. Counter model holding 14, deal_req_i at T → req_card_o low at T+1, card_valid_o at T+3 with idx = 14, rank = 1, suit = 1, points = 11; card_ready_i = 1 → SPIN, req_card_o = 1, dealt_count_o = 1.
3. Counter frozen at 0 → reject, req_card_o high for 3 cycles (counter → 3), resample → idx = 3, rank = 3, points = 3, latency T+8.
4. Index 26 already dealt, sampled again → one retry; index 29 accepted, rank = 3, suit = 2. card_ready_i held low 10 cycles → fields stable throughout.
5. Deal all 52 cards → deck_empty_o = 1, dealt_count_o = 52; a further deal_req_i is ignored (busy_o stays 0). shuffle_i → deck_empty_o = 0, count = 0; idx = 13 redealt → rank = 13, points = 10.
6. shuffle_i during PRESENT → card_valid_o drops the next cycle, bitmap empty. Async reset asserted mid-RESPIN → immediate return to reset values.
